// File: rtl/arb_mux.sv
// arb_mux: N-channel to one-output multiplexer with a single registered
// output stage. MODE=0 picks the channel named by Sel; MODE=1 arbitrates
// round-robin starting at a rotating pointer. One word per cycle when the
// downstream keeps OutReady high.
module arb_mux #(
    parameter int WIDTH    = 64,
    parameter int CHANNELS = 4,
    parameter int MODE     = 0,
    localparam int SW      = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                         Clk,
    input  logic                         ResetN,
    input  logic [CHANNELS*WIDTH-1:0]    In,
    input  logic [CHANNELS-1:0]          InValid,
    output logic [CHANNELS-1:0]          InReady,
    input  logic [SW-1:0]                Sel,
    output logic [WIDTH-1:0]             Out,
    output logic [SW-1:0]                OutChan,
    output logic                         OutValid,
    input  logic                         OutReady
);

    // channel count at index width + 1, so Sel/pointer compares never overflow
    localparam logic [SW:0] CH_W = CHANNELS[SW:0];

    logic [CHANNELS-1:0][WIDTH-1:0] in_arr;
    logic                           space;
    logic                           sel_ok;
    logic                           rr_vld;
    logic [SW-1:0]                  rr_gnt;
    logic [SW:0]                    idx;
    logic                           gnt_vld;
    logic [SW-1:0]                  gnt;
    logic                           xfer;
    logic [SW-1:0]                  ptr;

    assign in_arr = In;

    // output slot can take a word if empty or being drained this cycle
    assign space = !OutValid || OutReady;

    // external select: out-of-range Sel (non-power-of-two CHANNELS) never grants
    assign sel_ok = ({1'b0, Sel} < CH_W) && InValid[Sel];

    // round-robin scan from ptr; descending offsets so the lowest offset wins
    always_comb begin
        rr_vld = 1'b0;
        rr_gnt = '0;
        idx    = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + k[SW:0];
            if (idx >= CH_W)
                idx = idx - CH_W;
            if (InValid[idx[SW-1:0]]) begin
                rr_vld = 1'b1;
                rr_gnt = idx[SW-1:0];
            end
        end
    end

    assign gnt_vld = (MODE == 1) ? rr_vld : sel_ok;
    assign gnt     = (MODE == 1) ? rr_gnt : Sel;
    assign xfer    = gnt_vld && space;

    // per-lane accept strobe; depends only on valids, select and output state,
    // and is forced low while reset is held
    for (genvar i = 0; i < CHANNELS; i++) begin : g_rdy
        assign InReady[i] = ResetN & space & gnt_vld & (gnt == SW'(i));
    end

    // output register: load on transfer, otherwise drop valid once drained
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            Out      <= '0;
            OutChan  <= '0;
            OutValid <= 1'b0;
        end else if (xfer) begin
            Out      <= in_arr[gnt];
            OutChan  <= gnt;
            OutValid <= 1'b1;
        end else if (OutReady) begin
            OutValid <= 1'b0;
        end
    end

    // round-robin pointer moves just past the channel that was served
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN)
            ptr <= '0;
        else if (xfer && MODE == 1)
            ptr <= ({1'b0, gnt} == CH_W - 1'b1) ? '0 : gnt + 1'b1;
    end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 64: data width per channel.
REQ-002 SHALL have parameter CHANNELS, default 4, legal range 2..16: number of input channels.
REQ-003 SHALL have parameter MODE, default 0: 0 = external select via Sel, 1 = round-robin arbitration.
REQ-004 SHALL have Clk  input  1: single clock, all state updates on rising edge.
REQ-005 SHALL have ResetN  input  1: asynchronous active-low reset.
REQ-006 SHALL have In  input  CHANNELS*WIDTH: channel i data at bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have InValid  input  CHANNELS: per-channel data-valid.
REQ-008 SHALL have InReady  output  CHANNELS: per-channel accept strobe.
REQ-009 SHALL have Sel  input  SW = max(1, clog2(CHANNELS)): channel select, used only when MODE=0.
REQ-010 SHALL have Out  output  WIDTH: registered selected data.
REQ-011 SHALL have OutChan  output  SW: index of the channel that supplied Out.
REQ-012 SHALL have OutValid  output  1: Out/OutChan hold a valid word.
REQ-013 SHALL have OutReady  input  1: downstream accepts Out this cycle.

Function
REQ-014 SHALL hold one output register (Out, OutChan, OutValid).
REQ-015 SHALL define Space = !OutValid || OutReady, combinationally.
REQ-016 SHALL compute exactly one grant index G per cycle, or no grant; InReady[G] = Space, all other InReady bits 0.
REQ-017 MODE=0: G = Sel if Sel < CHANNELS and InValid[Sel]=1, else no grant; other channels' InValid are ignored.
REQ-018 MODE=1: G = first i with InValid[i]=1, scanning Ptr, Ptr+1, ... CHANNELS-1, 0, ... Ptr-1; no grant if InValid is all zero.
REQ-019 SHALL transfer on a cycle where a grant exists and Space=1: next edge loads Out=In[G], OutChan=G, OutValid=1.
REQ-020 MODE=1: SHALL set Ptr = G+1 on each transfer, wrapping CHANNELS-1 -> 0; Ptr SHALL be unchanged on cycles without a transfer.
REQ-021 SHALL clear OutValid on the next edge when OutValid=1, OutReady=1 and there is no transfer.
REQ-022 Simultaneous drain and transfer SHALL load the new word with OutValid remaining 1 (full throughput, one word per cycle).
REQ-023 While OutValid=1 and OutReady=0, Out and OutChan SHALL remain stable and all InReady SHALL be 0.
REQ-024 Latency SHALL be exactly one cycle from accepting transfer to OutValid=1; InReady SHALL have no combinational path from In.
REQ-025 Sel changes while OutValid=1 SHALL not alter Out or OutChan.
REQ-026 SHALL treat X-free Sel >= CHANNELS (non-power-of-two CHANNELS) as no grant.

Reset
REQ-027 While ResetN=0: OutValid=0, Out=0, OutChan=0, Ptr=0, InReady=all 0, asynchronously.
REQ-028 Reset asserted mid-operation SHALL discard the held word; the first grant after release SHALL use Ptr=0.
REQ-029 After ResetN deasserts, the first transfer SHALL occur no earlier than the first rising edge of Clk with ResetN=1.

Verification (WIDTH=64, CHANNELS=4)
REQ-030 MODE=0, In = {1024,256,4,3} (ch3..ch0), InValid=4'b1111, Sel=2, OutReady=1 -> InReady=4'b0100; after one edge Out=256, OutChan=2, OutValid=1.
REQ-031 MODE=0, Sel=1, InValid=4'b1101 -> InReady=0, OutValid stays 0; then InValid[1]=1 -> Out=4 on next edge.
REQ-032 MODE=1, InValid=4'b1111 constant, OutReady=1 -> OutChan sequence 0,1,2,3,0 on consecutive cycles, OutValid continuously 1.
REQ-033 MODE=1, Ptr=3, InValid=4'b0010 -> grant ch1, Ptr becomes 2; wrap from Ptr=3 with only ch0 valid -> grant ch0, Ptr=1.
REQ-034 Either mode, OutValid=1, OutReady=0 for 3 cycles with inputs changing -> Out/OutChan unchanged, InReady=0; OutReady=1 -> simultaneous drain and new load on the next edge.
REQ-035 Assert ResetN=0 between edges while OutValid=1 -> OutValid, Out, OutChan and InReady go to 0 immediately; after release, MODE=1 grants start from ch0.
